// File: rtl/led_sync_fifo.sv
// led_sync_fifo: single-clock LED datapath FIFO with thresholds, water level and sticky errors; `LED_FIFO_FWFT_EN selects first-word-fall-through reads
module led_sync_fifo #(
  parameter int DATA_WIDTH   = 24,
  parameter int DEPTH_WIDTH  = 12,
  parameter int AF_RESET_NUM = 1020,
  parameter int AE_RESET_NUM = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   wr_en,
  output logic                   wr_full,
  output logic                   almost_full,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_empty,
  output logic                   almost_empty,
  output logic [DEPTH_WIDTH:0]   water_level,
  input  logic                   thr_wr,
  input  logic [DEPTH_WIDTH:0]   thr_af,
  input  logic [DEPTH_WIDTH:0]   thr_ae,
  input  logic                   err_clr,
  output logic                   overflow,
  output logic                   underflow
);
  localparam int DW = DEPTH_WIDTH;
  localparam int N  = 1 << DW;
  logic [DATA_WIDTH-1:0] r_mem [N];
  logic [DW:0] r_wptr, r_rptr, r_level, r_af_num, r_ae_num;
  logic        r_full, r_af, r_ae, r_ovf, r_unf;
  logic [DW:0] w_wptr_n, w_rptr_n, w_level_n, w_af_num_n, w_ae_num_n;
  logic        w_wr, w_rd, w_empty;
  assign w_wr       = wr_en & !r_full & !rst;
  assign w_rd       = rd_en & !w_empty & !rst;
  assign w_wptr_n   = r_wptr + (DW+1)'(w_wr);
  assign w_rptr_n   = r_rptr + (DW+1)'(w_rd);
  assign w_level_n  = w_wptr_n - w_rptr_n;
  assign w_af_num_n = thr_wr ? thr_af : r_af_num;
  assign w_ae_num_n = thr_wr ? thr_ae : r_ae_num;
  // storage write port; empty blocks reads so no read-during-write bypass is needed
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wptr[DW-1:0]] <= wr_data;
  // pointers, level, flags and thresholds, all registered from accepted ops
  always_ff @(posedge clk)
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_af_num <= (DW+1)'(AF_RESET_NUM);
      r_ae_num <= (DW+1)'(AE_RESET_NUM);
    end else begin
      r_wptr   <= w_wptr_n;
      r_rptr   <= w_rptr_n;
      r_level  <= w_level_n;
      r_full   <= (w_wptr_n[DW] != w_rptr_n[DW]) && (w_wptr_n[DW-1:0] == w_rptr_n[DW-1:0]);
      r_af     <= w_level_n >= w_af_num_n;
      r_ae     <= w_level_n <= w_ae_num_n;
      r_af_num <= w_af_num_n;
      r_ae_num <= w_ae_num_n;
      r_ovf    <= !err_clr & (r_ovf | (wr_en & r_full));
      r_unf    <= !err_clr & (r_unf | (rd_en & w_empty));
    end
`ifdef LED_FIFO_FWFT_EN
  logic [DW:0]           r_fptr;
  logic                  r_head_v;
  logic [DATA_WIDTH-1:0] r_head;
  logic                  w_fetch;
  assign w_empty = !r_head_v;
  assign w_fetch = (r_fptr != r_wptr) && (!r_head_v || w_rd);
  // prefetch register keeps the head word visible; refilled from RAM when empty or popped
  always_ff @(posedge clk)
    if (rst) begin
      r_fptr   <= '0;
      r_head_v <= 1'b0;
      r_head   <= '0;
    end else begin
      if (w_fetch) begin
        r_head <= r_mem[r_fptr[DW-1:0]];
        r_fptr <= r_fptr + 1'b1;
      end
      r_head_v <= w_fetch | (r_head_v & !w_rd);
    end
  assign rd_data = r_head;
`else
  logic                  r_empty;
  logic [DATA_WIDTH-1:0] r_rd_data;
  assign w_empty = r_empty;
  // registered read port and empty flag; rd_data holds between accepted reads
  always_ff @(posedge clk)
    if (rst) begin
      r_empty   <= 1'b1;
      r_rd_data <= '0;
    end else begin
      r_empty <= w_wptr_n == w_rptr_n;
      if (w_rd) r_rd_data <= r_mem[r_rptr[DW-1:0]];
    end
  assign rd_data = r_rd_data;
`endif
  assign rd_empty     = w_empty;
  assign wr_full      = r_full;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign water_level  = r_level;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;
endmodule

// File: tb/tb_led_sync_fifo.sv
// tb_led_sync_fifo: randomized scoreboard bench for led_sync_fifo in standard read mode
module tb_led_sync_fifo;
  logic        clk = 0;
  logic        rst = 1;
  logic [23:0] wr_data = 0;
  logic        wr_en = 0, rd_en = 0, thr_wr = 0, err_clr = 0;
  logic [4:0]  thr_af = 0, thr_ae = 0;
  logic        wr_full, almost_full, rd_empty, almost_empty, overflow, underflow;
  logic [23:0] rd_data;
  logic [4:0]  water_level;
  int errs = 0, checks = 0;
  int m_q[$];
  int exp_q[$];
  int m_af = 14, m_ae = 2;
  bit m_ovf = 0, m_unf = 0;
  logic pend = 0;

  led_sync_fifo #(.DATA_WIDTH(24), .DEPTH_WIDTH(4), .AF_RESET_NUM(14), .AE_RESET_NUM(2)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .wr_full(wr_full),
    .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
    .almost_empty(almost_empty), .water_level(water_level), .thr_wr(thr_wr),
    .thr_af(thr_af), .thr_ae(thr_ae), .err_clr(err_clr), .overflow(overflow), .underflow(underflow));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) pend <= rd_en & !rd_empty & !rst;

  always @(negedge clk)
    if (pend) begin
      if (exp_q.size() == 0) chk("rd_data_unexpected", int'(rd_data), -1);
      else chk("rd_data", int'(rd_data), exp_q.pop_front());
    end

  task automatic check_state();
    chk("water_level", int'(water_level), m_q.size());
    chk("wr_full", int'(wr_full), int'(m_q.size() == 16));
    chk("rd_empty", int'(rd_empty), int'(m_q.size() == 0));
    chk("almost_full", int'(almost_full), int'(m_q.size() >= m_af));
    chk("almost_empty", int'(almost_empty), int'(m_q.size() <= m_ae));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("underflow", int'(underflow), int'(m_unf));
  endtask

  task automatic cyc(input logic w, input logic r, input logic [23:0] d, input logic t = 0,
                     input logic [4:0] ta = 0, input logic [4:0] te = 0, input logic c = 0, input logic x = 0);
    bit full, empty;
    wr_en = w; rd_en = r; wr_data = d; thr_wr = t; thr_af = ta; thr_ae = te; err_clr = c; rst = x;
    if (x) begin
      m_q.delete(); m_af = 14; m_ae = 2; m_ovf = 0; m_unf = 0;
    end else begin
      full  = m_q.size() == 16;
      empty = m_q.size() == 0;
      if (r && !empty) exp_q.push_back(m_q.pop_front());
      if (w && !full) m_q.push_back(int'(d));
      m_ovf = !c && (m_ovf || (w && full));
      m_unf = !c && (m_unf || (r && empty));
      if (t) begin m_af = int'(ta); m_ae = int'(te); end
    end
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  initial begin
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("reset_rd_data", int'(rd_data), 0);
    for (int i = 0; i < 17; i++) cyc(1, 0, 24'hFFFFFF - 24'(i));
    for (int i = 0; i < 17; i++) cyc(0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 0, 24'($urandom));
    for (int i = 0; i < 100; i++) cyc(1, 1, 24'($urandom));
    for (int i = 0; i < 8; i++) cyc(1, 0, 24'($urandom));
    cyc(1, 1, 24'h123456);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 24'($urandom));
    cyc(0, 0, 0, 1, 5'd4, 5'd1);
    cyc(1, 0, 24'hABCDEF);
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, 24'($urandom),
          $urandom_range(0, 19) == 0, 5'($urandom_range(0, 16)), 5'($urandom_range(0, 16)),
          $urandom_range(0, 15) == 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) cyc(1, 0, 24'($urandom));
    cyc(1, 1, 24'h55AA55, 0, 0, 0, 0, 1);
    chk("mid_reset_rd_data", int'(rd_data), 0);
    cyc(0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
